// File: rtl/am2940_pkg.sv
// am2940 DMA address generator: shared types
// Opcodes, counting modes and datapath width.
package am2940_pkg;

  localparam int W = 8;

  typedef enum logic [2:0] {
    OP_WRCR   = 3'd0,
    OP_RDCR   = 3'd1,
    OP_RDWC   = 3'd2,
    OP_RDAC   = 3'd3,
    OP_REINIT = 3'd4,
    OP_LDAD   = 3'd5,
    OP_LDWC   = 3'd6,
    OP_ENCT   = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_WCZ  = 2'd0,
    MODE_WCMP = 2'd1,
    MODE_ACMP = 2'd2,
    MODE_WCC  = 2'd3
  } mode_e;

endpackage

// File: rtl/am2940_counter.sv
// am2940 DMA: loadable up/down counter
// Carry-out is active-high here; the top inverts it.
module am2940_counter
  import am2940_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         cin,
  input  logic         down,
  output logic [W-1:0] q,
  output logic         co
);

  // reset wins, then load, then count
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (step && cin) begin
      q <= down ? q - 1'b1 : q + 1'b1;
    end
  end

  assign co = cin && (down ? (q == '0) : (q == '1));

endmodule

// File: rtl/am2940_dma.sv
// am2940 DMA address generator top
// Control/address/word-count registers and two counters.
module am2940_dma
  import am2940_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         oena,
  input  logic         cinac,
  input  logic         cinwc,
  input  logic [2:0]   instruction,
  inout  wire  [W-1:0] data,
  output logic [W-1:0] output_address,
  output logic         conac,
  output logic         conwc,
  output logic         done
);

  logic [2:0]   cr;
  logic [W-1:0] ar;
  logic [W-1:0] wcr;
  logic [W-1:0] ac;
  logic [W-1:0] wc;
  logic         co_ac;
  logic         co_wc;

  opcode_e op;
  mode_e   mode;
  assign op   = opcode_e'(instruction);
  assign mode = mode_e'(cr[1:0]);

  logic wr_cr, ld_ad, ld_wc, reinit, enct, rd;
  logic [W-1:0] rd_val;

  // instruction decode and read-back mux
  always_comb begin
    wr_cr  = 1'b0;
    ld_ad  = 1'b0;
    ld_wc  = 1'b0;
    reinit = 1'b0;
    enct   = 1'b0;
    rd     = 1'b0;
    rd_val = '0;
    unique case (op)
      OP_WRCR:   wr_cr = 1'b1;
      OP_RDCR: begin
        rd     = 1'b1;
        rd_val = {5'b00000, cr};
      end
      OP_RDWC: begin
        rd     = 1'b1;
        rd_val = wc;
      end
      OP_RDAC: begin
        rd     = 1'b1;
        rd_val = ac;
      end
      OP_REINIT: reinit = 1'b1;
      OP_LDAD:   ld_ad  = 1'b1;
      OP_LDWC:   ld_wc  = 1'b1;
      OP_ENCT:   enct   = 1'b1;
    endcase
  end

  // word counter tracks WCR only in the count-down/carry modes
  logic wc_tracks;
  assign wc_tracks = (mode == MODE_WCZ) || (mode == MODE_WCC);

  // control, address and word-count holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cr  <= '0;
      ar  <= '0;
      wcr <= '0;
    end else begin
      if (wr_cr) cr  <= data[2:0];
      if (ld_ad) ar  <= data;
      if (ld_wc) wcr <= data;
    end
  end

  logic [W-1:0] ac_load;
  logic [W-1:0] wc_load;
  assign ac_load = ld_ad ? data : ar;
  assign wc_load = !wc_tracks ? '0 : (ld_wc ? data : wcr);

  am2940_counter u_ac (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_ad || reinit),
    .load_val (ac_load),
    .step     (enct),
    .cin      (!cinac),
    .down     (cr[2]),
    .q        (ac),
    .co       (co_ac)
  );

  am2940_counter u_wc (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_wc || reinit),
    .load_val (wc_load),
    .step     (enct),
    .cin      (!cinwc && (mode != MODE_ACMP)),
    .down     (mode == MODE_WCZ),
    .q        (wc),
    .co       (co_wc)
  );

  assign conac = !co_ac;
  assign conwc = !co_wc;

  // terminal condition per mode
  always_comb begin
    done = 1'b0;
    unique case (mode)
      MODE_WCZ:  done = (wc == 8'h01);
      MODE_WCMP: done = ((wc + 8'h01) == wcr);
      MODE_ACMP: done = (ac == wcr);
      MODE_WCC:  done = (wc == 8'hFF);
    endcase
  end

  assign data           = rd ? rd_val : 'z;
  assign output_address = oena ? 'z : ac;

endmodule

// File: tb/tb_am2940_dma.sv
// am2940 DMA testbench
// Directed steps, cycle-level reference model, literal pins.
module tb_am2940_dma;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       oena = 1'b1;
  logic       cinac = 1'b1;
  logic       cinwc = 1'b1;
  logic [2:0] instruction = 3'd1;
  logic [7:0] din = 8'h00;
  wire  [7:0] data;
  logic [7:0] output_address;
  logic       conac, conwc, done;
  logic       drv;

  assign drv  = (instruction == 3'd0) || (instruction == 3'd5) || (instruction == 3'd6);
  assign data = drv ? din : 8'hzz;

  always #5 clk = ~clk;

  am2940_dma dut (
    .clk            (clk),
    .rst            (rst),
    .oena           (oena),
    .cinac          (cinac),
    .cinwc          (cinwc),
    .instruction    (instruction),
    .data           (data),
    .output_address (output_address),
    .conac          (conac),
    .conwc          (conwc),
    .done           (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference state
  logic [2:0] m_cr;
  logic [7:0] m_ar, m_ac, m_wcr, m_wc;
  bit         m_valid = 1'b0;

  // reference model advances on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_cr = 0; m_ar = 0; m_ac = 0; m_wcr = 0; m_wc = 0;
      m_valid = 1'b1;
    end else begin
      case (instruction)
        3'd0: m_cr = din[2:0];
        3'd4: begin
          m_ac = m_ar;
          m_wc = (m_cr[1:0] == 2'd1 || m_cr[1:0] == 2'd2) ? 8'h00 : m_wcr;
        end
        3'd5: begin m_ar = din; m_ac = din; end
        3'd6: begin
          m_wcr = din;
          m_wc = (m_cr[1:0] == 2'd1 || m_cr[1:0] == 2'd2) ? 8'h00 : din;
        end
        3'd7: begin
          if (!cinac) m_ac = m_cr[2] ? m_ac - 8'd1 : m_ac + 8'd1;
          if (!cinwc) begin
            if (m_cr[1:0] == 2'd0) m_wc = m_wc - 8'd1;
            else if (m_cr[1:0] != 2'd2) m_wc = m_wc + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic exp_done();
    case (m_cr[1:0])
      2'd0: return m_wc == 8'h01;
      2'd1: return 8'(m_wc + 8'd1) == m_wcr;
      2'd2: return m_ac == m_wcr;
      default: return m_wc == 8'hFF;
    endcase
  endfunction

  function automatic logic exp_conac();
    return !(!cinac && (m_cr[2] ? m_ac == 8'h00 : m_ac == 8'hFF));
  endfunction

  function automatic logic exp_conwc();
    if (m_cr[1:0] == 2'd2) return 1'b1;
    return !(!cinwc && (m_cr[1:0] == 2'd0 ? m_wc == 8'h00 : m_wc == 8'hFF));
  endfunction

  task automatic compare();
    chk("done", {7'd0, done}, {7'd0, exp_done()});
    chk("conac", {7'd0, conac}, {7'd0, exp_conac()});
    chk("conwc", {7'd0, conwc}, {7'd0, exp_conwc()});
    if (!oena) chk("addr", output_address, m_ac);
    case (instruction)
      3'd1: chk("rdcr", data, {5'd0, m_cr});
      3'd2: chk("rdwc", data, m_wc);
      3'd3: chk("rdac", data, m_ac);
      default: ;
    endcase
  endtask

  task automatic step(input logic r, input logic [2:0] op, input logic [7:0] d,
                      input logic ca, input logic cw, input logic oe);
    @(negedge clk);
    #2;
    rst = r; instruction = op; din = d;
    cinac = ca; cinwc = cw; oena = oe;
  endtask

  task automatic enct(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd7, 8'h00, 0, 0, 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (m_valid) compare();
      end
    join_none

    step(1, 3'd1, 8'h00, 1, 1, 1);
    step(1, 3'd1, 8'h00, 1, 1, 1);
    step(0, 3'd1, 8'h00, 1, 1, 1);
    #1;
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_conac", {7'd0, conac}, 8'h01);
    chk("rst_conwc", {7'd0, conwc}, 8'h01);
    chk("rst_cr", data, 8'h00);

    // mode 0, increment
    step(0, 3'd0, 8'h00, 1, 1, 0);
    step(0, 3'd6, 8'h09, 1, 1, 0);
    step(0, 3'd5, 8'h01, 1, 1, 0);
    enct(1);
    #1 chk("m0_first", output_address, 8'h01);
    chk("m0_first_done", {7'd0, done}, 8'h00);
    enct(8);
    #1 chk("m0_last", output_address, 8'h09);
    chk("m0_last_done", {7'd0, done}, 8'h01);

    // mode 1, increment
    step(0, 3'd0, 8'h01, 1, 1, 0);
    step(0, 3'd6, 8'h09, 1, 1, 0);
    step(0, 3'd5, 8'h0F, 1, 1, 0);
    step(0, 3'd2, 8'h00, 1, 1, 0);
    #1 chk("m1_rdwc", data, 8'h00);
    enct(9);
    #1 chk("m1_last", output_address, 8'h17);
    chk("m1_done", {7'd0, done}, 8'h01);

    // mode 1, decrement from REINIT
    step(0, 3'd0, 8'h05, 1, 1, 0);
    step(0, 3'd4, 8'h00, 1, 1, 0);
    enct(1);
    #1 chk("m5_first", output_address, 8'h0F);
    enct(8);
    #1 chk("m5_last", output_address, 8'h07);
    chk("m5_done", {7'd0, done}, 8'h01);

    // mode 2, address compare across wrap
    step(0, 3'd0, 8'h02, 1, 1, 0);
    step(0, 3'd5, 8'hFE, 1, 1, 0);
    step(0, 3'd6, 8'h02, 1, 1, 0);
    enct(2);
    #1 chk("m2_ff", output_address, 8'hFF);
    chk("m2_conac", {7'd0, conac}, 8'h00);
    chk("m2_conwc", {7'd0, conwc}, 8'h01);
    enct(3);
    #1 chk("m2_last", output_address, 8'h02);
    chk("m2_done", {7'd0, done}, 8'h01);

    // mode 3, decrement, word carry
    step(0, 3'd0, 8'h07, 1, 1, 0);
    step(0, 3'd5, 8'hF1, 1, 1, 0);
    step(0, 3'd6, 8'hF8, 1, 1, 0);
    enct(8);
    #1 chk("m7_addr", output_address, 8'hEA);
    chk("m7_done", {7'd0, done}, 8'h01);
    chk("m7_conwc", {7'd0, conwc}, 8'h00);
    enct(2);
    step(0, 3'd7, 8'h00, 1, 1, 0);
    step(0, 3'd7, 8'h00, 0, 1, 1);

    // reset mid-count
    step(1, 3'd7, 8'h00, 0, 0, 0);
    step(0, 3'd1, 8'h00, 1, 1, 1);
    #1 chk("r_cr", data, 8'h00);
    step(0, 3'd3, 8'h00, 1, 1, 1);
    #1 chk("r_ac", data, 8'h00);
    step(0, 3'd2, 8'h00, 1, 1, 1);
    #1 chk("r_wc", data, 8'h00);
    chk("r_done", {7'd0, done}, 8'h00);
    step(0, 3'd1, 8'h00, 1, 1, 1);
    step(0, 3'd1, 8'h00, 1, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
